binary_to_gray: RTL and testbench

BINARY_TO_GRAY -- requirements
Module: binary_to_gray

---
 rtl/binary_to_gray.sv | 104 ++++++++++
 tb/tb_binary_to_gray.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_gray.sv
// binary_to_gray
//   Registered binary-to-Gray converter with a one-bit-change indicator.
//   Each accepted binary word is converted as gray = binary ^ (binary >> 1)
//   and presented one cycle later together with a one-cycle gray_valid pulse.
//   single_step reports whether the new Gray word differs from the previous
//   accepted one in exactly one bit. The first word after reset has no
//   predecessor and always reports 0.
//
//   Optional build macro: BINARY_TO_GRAY_CHECK_EN
//     When defined, the registered Gray word is converted back to binary and
//     compared with the registered accepted binary word whenever gray_valid
//     is high. A mismatch sets roundtrip_err, which stays set until reset.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   binary_valid  qualifies binary this cycle (no backpressure)
//   binary        unsigned binary input, WIDTH bits
//   gray          registered Gray code of the last accepted word
//   gray_valid    one-cycle pulse: gray was updated on this edge
//   single_step   registered: last accepted gray differs from its predecessor in one bit
//   roundtrip_err sticky self-check failure (only with BINARY_TO_GRAY_CHECK_EN)
module binary_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             binary_valid,
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             gray_valid,
  output logic             single_step
`ifdef BINARY_TO_GRAY_CHECK_EN
  ,
  output logic             roundtrip_err
`endif
);

  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] gray_diff;
  logic             diff_seen;
  logic             diff_multi;
  logic             one_bit_diff;
  logic             have_prev;

  // Exactly-one-bit test kept bitwise: track "some bit set" and
  // "a second bit set" while scanning the difference vector.
  always_comb begin
    gray_next  = binary ^ (binary >> 1);
    gray_diff  = gray_next ^ gray;
    diff_seen  = 1'b0;
    diff_multi = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff_multi = diff_multi | (diff_seen & gray_diff[i]);
      diff_seen  = diff_seen | gray_diff[i];
    end
    one_bit_diff = diff_seen & ~diff_multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray        <= '0;
      gray_valid  <= 1'b0;
      single_step <= 1'b0;
      have_prev   <= 1'b0;
    end else begin
      gray_valid <= binary_valid;
      if (binary_valid) begin
        gray        <= gray_next;
        single_step <= have_prev & one_bit_diff;
        have_prev   <= 1'b1;
      end
    end
  end

`ifdef BINARY_TO_GRAY_CHECK_EN
  logic [WIDTH-1:0] binary_q;
  logic [WIDTH-1:0] gray_back;

  // b[i] is the XOR of all Gray bits from i upward; the reduction form
  // avoids a bit-serial chain that refers back to itself.
  always_comb begin
    gray_back = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gray_back[i] = ^(gray >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      binary_q      <= '0;
      roundtrip_err <= 1'b0;
    end else begin
      if (binary_valid) begin
        binary_q <= binary;
      end
      if (gray_valid && (gray_back != binary_q)) begin
        roundtrip_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// tb_binary_to_gray
//   Directed, table-driven bench for binary_to_gray at WIDTH=4 and WIDTH=2,
//   plus an exhaustive WIDTH=8 round-trip sweep when BINARY_TO_GRAY_CHECK_EN
//   is defined.
module tb_binary_to_gray;

  logic       clk;
  logic       rst;
  logic       binary_valid;
  logic [3:0] binary;
  logic [3:0] gray;
  logic       gray_valid;
  logic       single_step;

  logic       rst2;
  logic       bv2;
  logic [1:0] bin2;
  logic [1:0] gray2;
  logic       gv2;
  logic       ss2;

`ifdef BINARY_TO_GRAY_CHECK_EN
  logic       rt_err4;
  logic       rt_err2;
  logic       rst8;
  logic       bv8;
  logic [7:0] bin8;
  logic [7:0] gray8;
  logic       gv8;
  logic       ss8;
  logic       rt_err8;
`endif

  int total;
  int bad;

  binary_to_gray #(.WIDTH(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .binary_valid (binary_valid),
    .binary       (binary),
    .gray         (gray),
    .gray_valid   (gray_valid),
    .single_step  (single_step)
`ifdef BINARY_TO_GRAY_CHECK_EN
    ,
    .roundtrip_err(rt_err4)
`endif
  );

  binary_to_gray #(.WIDTH(2)) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .binary_valid (bv2),
    .binary       (bin2),
    .gray         (gray2),
    .gray_valid   (gv2),
    .single_step  (ss2)
`ifdef BINARY_TO_GRAY_CHECK_EN
    ,
    .roundtrip_err(rt_err2)
`endif
  );

`ifdef BINARY_TO_GRAY_CHECK_EN
  binary_to_gray #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst8),
    .binary_valid (bv8),
    .binary       (bin8),
    .gray         (gray8),
    .gray_valid   (gv8),
    .single_step  (ss8),
    .roundtrip_err(rt_err8)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       ss;
  } vec4_t;

  typedef struct {
    logic [1:0] bin;
    logic [1:0] gray;
    logic       ss;
  } vec2_t;

  vec4_t sweep[16];
  vec2_t seq2[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] b);
    @(negedge clk);
    rst          = r;
    binary_valid = v;
    binary       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic r, input logic v, input logic [1:0] b);
    @(negedge clk);
    rst2 = r;
    bv2  = v;
    bin2 = b;
    @(posedge clk);
    #1;
  endtask

`ifdef BINARY_TO_GRAY_CHECK_EN
  task automatic step8(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst8 = r;
    bv8  = v;
    bin8 = b;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;

    sweep[0]  = '{4'd0,  4'b0000, 1'b0};
    sweep[1]  = '{4'd1,  4'b0001, 1'b1};
    sweep[2]  = '{4'd2,  4'b0011, 1'b1};
    sweep[3]  = '{4'd3,  4'b0010, 1'b1};
    sweep[4]  = '{4'd4,  4'b0110, 1'b1};
    sweep[5]  = '{4'd5,  4'b0111, 1'b1};
    sweep[6]  = '{4'd6,  4'b0101, 1'b1};
    sweep[7]  = '{4'd7,  4'b0100, 1'b1};
    sweep[8]  = '{4'd8,  4'b1100, 1'b1};
    sweep[9]  = '{4'd9,  4'b1101, 1'b1};
    sweep[10] = '{4'd10, 4'b1111, 1'b1};
    sweep[11] = '{4'd11, 4'b1110, 1'b1};
    sweep[12] = '{4'd12, 4'b1010, 1'b1};
    sweep[13] = '{4'd13, 4'b1011, 1'b1};
    sweep[14] = '{4'd14, 4'b1001, 1'b1};
    sweep[15] = '{4'd15, 4'b1000, 1'b1};

    seq2[0] = '{2'd0, 2'b00, 1'b0};
    seq2[1] = '{2'd1, 2'b01, 1'b1};
    seq2[2] = '{2'd2, 2'b11, 1'b1};
    seq2[3] = '{2'd3, 2'b10, 1'b1};
    seq2[4] = '{2'd0, 2'b00, 1'b1};

    rst          = 1'b1;
    binary_valid = 1'b0;
    binary       = '0;
    rst2         = 1'b1;
    bv2          = 1'b0;
    bin2         = '0;
`ifdef BINARY_TO_GRAY_CHECK_EN
    rst8 = 1'b1;
    bv8  = 1'b0;
    bin8 = '0;
`endif

    // Reset state
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    chk("reset_gray", {28'd0, gray}, 32'd0);
    chk("reset_gv", {31'd0, gray_valid}, 32'd0);
    chk("reset_ss", {31'd0, single_step}, 32'd0);

    // Full sweep 0..15, one valid cycle every 100 time units
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, sweep[i].bin);
      chk($sformatf("sweep_gray[%0d]", i), {28'd0, gray}, {28'd0, sweep[i].gray});
      chk($sformatf("sweep_gv[%0d]", i), {31'd0, gray_valid}, 32'd1);
      chk($sformatf("sweep_ss[%0d]", i), {31'd0, single_step}, {31'd0, sweep[i].ss});
      step(1'b0, 1'b0, 4'd0);
      chk($sformatf("sweep_idle_gv[%0d]", i), {31'd0, gray_valid}, 32'd0);
      chk($sformatf("sweep_idle_gray[%0d]", i), {28'd0, gray}, {28'd0, sweep[i].gray});
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 4'd0);
    end

    // 15 then 0 back-to-back: wrap-around is a single step
    step(1'b0, 1'b1, 4'd15);
    chk("wrap_gray15", {28'd0, gray}, 32'b1000);
    chk("wrap_gv15", {31'd0, gray_valid}, 32'd1);
    chk("wrap_ss15_repeat", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b1, 4'd0);
    chk("wrap_gray0", {28'd0, gray}, 32'b0000);
    chk("wrap_gv0", {31'd0, gray_valid}, 32'd1);
    chk("wrap_ss0", {31'd0, single_step}, 32'd1);
    step(1'b0, 1'b0, 4'd0);
    chk("ss_hold_idle", {31'd0, single_step}, 32'd1);

    // 5, three idle cycles, 5 again
    step(1'b0, 1'b1, 4'd5);
    chk("hold_gray_first", {28'd0, gray}, 32'b0111);
    chk("hold_ss_first", {31'd0, single_step}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'd3);
      chk($sformatf("hold_gray_idle[%0d]", k), {28'd0, gray}, 32'b0111);
      chk($sformatf("hold_gv_idle[%0d]", k), {31'd0, gray_valid}, 32'd0);
    end
    step(1'b0, 1'b1, 4'd5);
    chk("hold_gray_second", {28'd0, gray}, 32'b0111);
    chk("hold_gv_second", {31'd0, gray_valid}, 32'd1);
    chk("hold_ss_second", {31'd0, single_step}, 32'd0);

    // Reset wins over a valid word in the same cycle
    step(1'b1, 1'b1, 4'd9);
    chk("rstpri_gray", {28'd0, gray}, 32'd0);
    chk("rstpri_gv", {31'd0, gray_valid}, 32'd0);
    chk("rstpri_ss", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b1, 4'd9);
    chk("rstpri_gray9", {28'd0, gray}, 32'b1101);
    chk("rstpri_ss9", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b1, 4'd8);
    chk("after_rst_gray8", {28'd0, gray}, 32'b1100);
    chk("after_rst_ss8", {31'd0, single_step}, 32'd1);

    // Mid-stream reset clears history: gray 0001 vs reset value 0000 is one
    // bit apart but must still report 0 as a first word
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd1);
    chk("hist_gray1", {28'd0, gray}, 32'b0001);
    chk("hist_ss1", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b1, 4'd1);
    chk("repeat_ss", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b1, 4'd0);
    chk("adj_ss", {31'd0, single_step}, 32'd1);
    step(1'b0, 1'b1, 4'd2);
    chk("jump_gray2", {28'd0, gray}, 32'b0011);
    chk("jump_ss", {31'd0, single_step}, 32'd0);
    step(1'b0, 1'b0, 4'd0);

    // WIDTH=2 sequence
    step2(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step2(1'b0, 1'b1, seq2[i].bin);
      chk($sformatf("w2_gray[%0d]", i), {30'd0, gray2}, {30'd0, seq2[i].gray});
      chk($sformatf("w2_gv[%0d]", i), {31'd0, gv2}, 32'd1);
      chk($sformatf("w2_ss[%0d]", i), {31'd0, ss2}, {31'd0, seq2[i].ss});
    end
    step2(1'b0, 1'b0, 2'd0);
    chk("w2_idle_gv", {31'd0, gv2}, 32'd0);

`ifdef BINARY_TO_GRAY_CHECK_EN
    chk("rt_err4", {31'd0, rt_err4}, 32'd0);
    chk("rt_err2", {31'd0, rt_err2}, 32'd0);
    step8(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      step8(1'b0, 1'b1, b);
      chk($sformatf("w8_gray[%0d]", i), {24'd0, gray8}, {24'd0, b ^ (b >> 1)});
      chk($sformatf("w8_err[%0d]", i), {31'd0, rt_err8}, 32'd0);
    end
    step8(1'b0, 1'b0, 8'd0);
    step8(1'b0, 1'b0, 8'd0);
    chk("w8_err_final", {31'd0, rt_err8}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
